// File: rtl/feature_pingpong_sched_pkg.sv
// Shared definitions for the feature-memory ping-pong scheduler: bank state
// encodings, bank count and the default stall-counter width.
package feature_pingpong_sched_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY     = 2'b00,
        BANK_FILLING   = 2'b01,
        BANK_FULL      = 2'b10,
        BANK_COMPUTING = 2'b11
    } bank_state_e;

    localparam int unsigned NUM_FEATURE_BANKS       = 2;
    localparam int unsigned STALL_CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/feature_bank_state.sv
// Single feature bank lifecycle: EMPTY -> FILLING -> FULL -> COMPUTING -> EMPTY.
// Each set_* only takes effect from its legal predecessor state; clear wins.
module feature_bank_state
    import feature_pingpong_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        set_fill,
    input  logic        set_full,
    input  logic        set_comp,
    input  logic        set_empty,
    output bank_state_e state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BANK_EMPTY;
        end else if (clear) begin
            state <= BANK_EMPTY;
        end else begin
            unique case (state)
                BANK_EMPTY:     if (set_fill)  state <= BANK_FILLING;
                BANK_FILLING:   if (set_full)  state <= BANK_FULL;
                BANK_FULL:      if (set_comp)  state <= BANK_COMPUTING;
                BANK_COMPUTING: if (set_empty) state <= BANK_EMPTY;
                default:                       state <= BANK_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/feature_pingpong_sched.sv
// Ping-pong scheduler: hands one feature bank to the fetcher and the other to
// the line-buffer reader, swapping them in strict alternation.
module feature_pingpong_sched
    import feature_pingpong_sched_pkg::*;
#(
    parameter int unsigned STALL_CNT_WIDTH = STALL_CNT_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fill_req,
    output logic                       fill_grant,
    output logic                       fill_bank,
    input  logic                       fill_done,
    input  logic                       comp_req,
    output logic                       comp_grant,
    output logic                       comp_bank,
    input  logic                       comp_done,
    input  logic                       flush,
    output logic [3:0]                 bank_state,
    output logic                       busy,
    output logic                       proto_err,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    bank_state_e banks [NUM_FEATURE_BANKS];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        fill_start;
    logic        fill_accept;
    logic        comp_start;
    logic        comp_accept;

    // Grants look only at registered bank state, so a bank turning FULL on
    // this edge is not eligible for compute until the following one.
    always_comb begin
        fill_start  = !fill_grant && fill_req && (banks[wr_ptr] == BANK_EMPTY);
        fill_accept = fill_grant && fill_done;
        comp_start  = !comp_grant && comp_req && (banks[rd_ptr] == BANK_FULL);
        comp_accept = comp_grant && comp_done;
    end

    for (genvar b = 0; b < NUM_FEATURE_BANKS; b++) begin : g_bank
        feature_bank_state u_bank (
            .clk       (clk),
            .rst       (rst),
            .clear     (flush),
            .set_fill  (fill_start && (wr_ptr == 1'(b))),
            .set_full  (fill_accept && (fill_bank == 1'(b))),
            .set_comp  (comp_start && (rd_ptr == 1'(b))),
            .set_empty (comp_accept && (comp_bank == 1'(b))),
            .state     (banks[b])
        );
    end

    assign bank_state = {banks[1], banks[0]};
    assign busy       = (banks[0] != BANK_EMPTY) || (banks[1] != BANK_EMPTY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fill_grant   <= 1'b0;
            fill_bank    <= 1'b0;
            comp_grant   <= 1'b0;
            comp_bank    <= 1'b0;
            proto_err    <= 1'b0;
            stall_cycles <= '0;
        end else if (flush) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fill_grant   <= 1'b0;
            fill_bank    <= 1'b0;
            comp_grant   <= 1'b0;
            comp_bank    <= 1'b0;
            proto_err    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (fill_accept) begin
                fill_grant <= 1'b0;
                wr_ptr     <= ~wr_ptr;
            end else if (fill_start) begin
                fill_grant <= 1'b1;
                fill_bank  <= wr_ptr;
            end

            if (comp_accept) begin
                comp_grant <= 1'b0;
                rd_ptr     <= ~rd_ptr;
            end else if (comp_start) begin
                comp_grant <= 1'b1;
                comp_bank  <= rd_ptr;
            end

            if ((fill_done && !fill_grant) || (comp_done && !comp_grant)) begin
                proto_err <= 1'b1;
            end

            if (comp_req && !comp_grant && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_feature_pingpong_sched.sv
// Bench for feature_pingpong_sched: directed stimulus, a per-cycle comparison
// against a bank-lifecycle model, and literal expectations at key points.
module tb_feature_pingpong_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fill_req = 1'b0;
    logic        fill_done = 1'b0;
    logic        comp_req = 1'b0;
    logic        comp_done = 1'b0;
    logic        flush = 1'b0;

    logic        fill_grant, fill_bank, comp_grant, comp_bank, busy, proto_err;
    logic [3:0]  bank_state;
    logic [15:0] stall_cycles;

    logic        s_fill_grant, s_fill_bank, s_comp_grant, s_comp_bank, s_busy, s_proto_err;
    logic [3:0]  s_bank_state;
    logic [3:0]  s_stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    feature_pingpong_sched dut (
        .clk          (clk),
        .rst          (rst),
        .fill_req     (fill_req),
        .fill_grant   (fill_grant),
        .fill_bank    (fill_bank),
        .fill_done    (fill_done),
        .comp_req     (comp_req),
        .comp_grant   (comp_grant),
        .comp_bank    (comp_bank),
        .comp_done    (comp_done),
        .flush        (flush),
        .bank_state   (bank_state),
        .busy         (busy),
        .proto_err    (proto_err),
        .stall_cycles (stall_cycles)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    feature_pingpong_sched #(.STALL_CNT_WIDTH(4)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .fill_req     (fill_req),
        .fill_grant   (s_fill_grant),
        .fill_bank    (s_fill_bank),
        .fill_done    (fill_done),
        .comp_req     (comp_req),
        .comp_grant   (s_comp_grant),
        .comp_bank    (s_comp_bank),
        .comp_done    (comp_done),
        .flush        (flush),
        .bank_state   (s_bank_state),
        .busy         (s_busy),
        .proto_err    (s_proto_err),
        .stall_cycles (s_stall_cycles)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bank lifecycle per bank, pointers derived from completion counts.
    logic [1:0] mb [2];
    logic [1:0] ob [2];
    bit         m_fg, m_cg, m_err;
    int         m_fb, m_cb, n_fills, n_comps, m_stall;
    bit         o_fg, o_cg;

    task automatic m_reset();
        mb[0] = 2'd0; mb[1] = 2'd0;
        m_fg = 0; m_cg = 0; m_err = 0;
        m_fb = 0; m_cb = 0; n_fills = 0; n_comps = 0; m_stall = 0;
    endtask

    initial m_reset();

    always @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            m_reset();
        end else begin
            ob[0] = mb[0]; ob[1] = mb[1];
            o_fg = m_fg; o_cg = m_cg;
            if (comp_req && !o_cg) m_stall++;
            if (fill_done && !o_fg) m_err = 1;
            if (comp_done && !o_cg) m_err = 1;
            if (fill_done && o_fg) begin
                mb[m_fb] = 2'd2;
                m_fg = 0;
                n_fills++;
            end else if (!o_fg && fill_req && ob[n_fills % 2] == 2'd0) begin
                m_fb = n_fills % 2;
                mb[m_fb] = 2'd1;
                m_fg = 1;
            end
            if (comp_done && o_cg) begin
                mb[m_cb] = 2'd0;
                m_cg = 0;
                n_comps++;
            end else if (!o_cg && comp_req && ob[n_comps % 2] == 2'd2) begin
                m_cb = n_comps % 2;
                mb[m_cb] = 2'd3;
                m_cg = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_bank_state", bank_state, {mb[1], mb[0]});
        chk("m_fill_grant", fill_grant, m_fg);
        chk("m_comp_grant", comp_grant, m_cg);
        if (m_fg) chk("m_fill_bank", fill_bank, m_fb);
        if (m_cg) chk("m_comp_bank", comp_bank, m_cb);
        chk("m_busy", busy, (mb[0] != 2'd0) || (mb[1] != 2'd0));
        chk("m_proto_err", proto_err, m_err);
        chk("m_stall16", stall_cycles, (m_stall > 65535) ? 65535 : m_stall);
        chk("m_stall4", s_stall_cycles, (m_stall > 15) ? 15 : m_stall);
        chk("m_small_state", s_bank_state, {mb[1], mb[0]});
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_bank_state", bank_state, 4'b0000);
        chk("reset_grants", {fill_grant, comp_grant, fill_bank, comp_bank}, 4'b0000);
        chk("reset_busy_err", {busy, proto_err}, 2'b00);
        chk("reset_stall", stall_cycles, 0);
        rst = 1'b1;

        // 1: basic fill
        fill_req = 1; step(); fill_req = 0;
        chk("t1_grant", {fill_grant, fill_bank}, 2'b10);
        chk("t1_state", bank_state, 4'b0001);
        fill_done = 1; step(); fill_done = 0;
        chk("t1_full", bank_state, 4'b0010);
        chk("t1_released", fill_grant, 0);

        // 2: ping-pong across both banks
        comp_req = 1; fill_req = 1; step(); comp_req = 0; fill_req = 0;
        chk("t2_comp", {comp_grant, comp_bank}, 2'b10);
        chk("t2_fill_b1", {fill_grant, fill_bank}, 2'b11);
        chk("t2_state", bank_state, 4'b0111);
        comp_done = 1; step(); comp_done = 0;
        fill_done = 1; step(); fill_done = 0;
        chk("t2_state2", bank_state, 4'b1000);
        comp_req = 1; step(); comp_req = 0;
        chk("t2_comp_b1", {comp_grant, comp_bank}, 2'b11);
        comp_done = 1; step(); comp_done = 0;
        chk("t2_empty", {bank_state, busy}, 5'b00000);

        // 3: both banks full stall the fetcher
        flush = 1; step(); flush = 0;
        fill_req = 1; step(); fill_req = 0;
        fill_done = 1; step(); fill_done = 0;
        fill_req = 1; step(); fill_req = 0;
        fill_done = 1; step(); fill_done = 0;
        chk("t3_both_full", bank_state, 4'b1010);
        fill_req = 1;
        repeat (10) step();
        chk("t3_stalled", fill_grant, 0);
        comp_req = 1; step(); comp_req = 0;
        chk("t3_comp_b0", {comp_grant, comp_bank}, 2'b10);
        comp_done = 1; step(); comp_done = 0;
        chk("t3_not_yet", fill_grant, 0);
        step();
        chk("t3_regrant", {fill_grant, fill_bank}, 2'b10);
        chk("t3_state", bank_state, 4'b1001);
        fill_req = 0;

        // 4: starvation and saturation
        flush = 1; step(); flush = 0;
        comp_req = 1;
        repeat (20) step();
        comp_req = 0;
        chk("t4_stall", stall_cycles, 20);
        chk("t4_no_grant", comp_grant, 0);
        chk("t4_sat4", s_stall_cycles, 4'hF);

        // 5: protocol error, then flush
        flush = 1; step(); flush = 0;
        fill_req = 1; step(); fill_req = 0;
        fill_done = 1; step(); fill_done = 0;
        comp_done = 1; step(); comp_done = 0;
        chk("t5_err", proto_err, 1);
        chk("t5_state_kept", bank_state, 4'b0010);
        flush = 1; step(); flush = 0;
        chk("t5_flush", {proto_err, busy, fill_grant, comp_grant, bank_state}, 8'h00);
        chk("t5_flush_stall", stall_cycles, 0);

        // 6: async reset while computing
        fill_req = 1; step(); fill_req = 0;
        fill_done = 1; step(); fill_done = 0;
        comp_req = 1; step(); comp_req = 0;
        chk("t6_computing", {comp_grant, bank_state}, 5'b10011);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_clear", {comp_grant, fill_grant, busy, bank_state}, 7'b0);
        #1 rst = 1'b1;
        fill_req = 1; step(); fill_req = 0;
        chk("t6_after", {fill_grant, fill_bank}, 2'b10);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/feature_pingpong_sched.md
Name: feature_pingpong_sched

Overview:
- Ping-pong scheduler for the two scratchpad feature memory groups (group 0 / group 1).
- Grants one bank to the input feature fetcher for filling and the other bank to the line-buffer reader for compute, then swaps the two banks as each side completes.
- Drives the fetcher's write-bank select (feeding the feature write switch) and the reader's feature_in_select.
- Sits between top_fsm/instruction_decode handshakes and the feature memory datapath.

Parameters:
- STALL_CNT_WIDTH, 16, width of the saturating compute-stall counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- fill_req  input  1  fetcher requests a bank to fill; level, held until fill_grant
- fill_grant  output  1  fill bank granted; held until fill_done accepted
- fill_bank  output  1  bank being filled (0/1); valid while fill_grant=1
- fill_done  input  1  one-cycle pulse: fetcher finished writing the granted bank
- comp_req  input  1  reader requests a full bank; level, held until comp_grant
- comp_grant  output  1  compute bank granted; held until comp_done accepted
- comp_bank  output  1  bank being read; valid while comp_grant=1
- comp_done  input  1  one-cycle pulse: reader finished with the granted bank
- flush  input  1  synchronous clear of all scheduling state
- bank_state  output  4  {bank1[1:0], bank0[1:0]} current bank states
- busy  output  1  any bank not EMPTY
- proto_err  output  1  sticky: done pulse received with no matching grant
- stall_cycles  output  STALL_CNT_WIDTH  saturating count of cycles with comp_req=1 and comp_grant=0

Behaviour:
- Per-bank state, 2 bits: EMPTY=00, FILLING=01, FULL=10, COMPUTING=11.
- Registers: wr_ptr and rd_ptr (1 bit each).
- Reset (rst=0, async): both banks EMPTY, wr_ptr=rd_ptr=0, fill_grant=comp_grant=0, fill_bank=comp_bank=0, busy=0, proto_err=0, stall_cycles=0.
- Fill grant: if fill_grant=0, fill_req=1 and bank[wr_ptr]==EMPTY at edge N, then from N+1: fill_grant=1, fill_bank=wr_ptr, bank[wr_ptr]=FILLING.
- Fill complete: fill_done=1 while fill_grant=1 at edge M gives, from M+1: bank[fill_bank]=FULL, fill_grant=0, wr_ptr toggles.
  - A new fill grant needs at least one idle cycle, so the earliest regrant is M+2.
- Compute grant: if comp_grant=0, comp_req=1 and the registered bank[rd_ptr]==FULL, then from the next cycle: comp_grant=1, comp_bank=rd_ptr, bank=COMPUTING.
- Compute complete: comp_done=1 while comp_grant=1 gives bank[comp_bank]=EMPTY, comp_grant=0, rd_ptr toggles.
- Same-bank back-to-back: fill_done and comp_req on the same edge give no comp_grant on that edge (bank is not yet FULL). comp_grant rises at M+2, i.e. one cycle after FULL is visible.
- Different banks: fill and compute grant/done events on the same edge are all applied; they are independent.
- Bank order is strict alternation: banks are consumed in fill order because both pointers toggle.
- Both banks FULL: fill_req stalls (no grant) until comp_done frees a bank.
- Both banks EMPTY: comp_req stalls; stall_cycles increments each such cycle and saturates at all-ones (no wrap).
- fill_done with fill_grant=0, or comp_done with comp_grant=0: the pulse is ignored, state is unchanged, and proto_err sets to 1 (sticky).
- flush=1: has priority over all other inputs. Next cycle equals the reset state, except stall_cycles, which is also cleared. Any in-flight grant is dropped with no done required.
- busy = OR over banks of (state != EMPTY), registered along with the states.
- All outputs are registered; no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header (network_para.vh style) holds:
  - the bank state encodings BANK_EMPTY/FILLING/FULL/COMPUTING;
  - NUM_FEATURE_BANKS=2;
  - STALL_CNT_WIDTH default.
- One natural sub-module, feature_bank_state: a single-bank 4-state FSM with set_fill / set_full / set_comp / set_empty / clear inputs. It is instantiated twice; the top level holds the pointers, grant logic, error flag and counter.

Test Plan:
1. Reset then fill_req=1 → fill_grant=1, fill_bank=0 one cycle later; bank_state=4'b0001; fill_done pulse → bank_state=4'b0010, wr_ptr→1.
2. Full ping-pong: fill bank0, comp_req → comp_grant, comp_bank=0, while a second fill_req gets fill_bank=1. comp_done then fill_done → bank_state=4'b1000; the next comp_grant has comp_bank=1.
3. Both full: fill banks 0 and 1 with no compute, third fill_req held 10 cycles → fill_grant stays 0. A comp_done on bank0 → fill_grant with fill_bank=0 two cycles later.
4. Starvation: comp_req=1 for 20 cycles with both banks EMPTY → stall_cycles=20, comp_grant=0. Force a counter near max → it saturates at 16'hFFFF.
5. Protocol error: comp_done pulse with no grant → proto_err=1, bank_state unchanged; flush → proto_err=0, all outputs at reset values.
6. Async reset asserted mid-COMPUTING (rst low between edges) → outputs clear immediately without a clock edge; after release, fill_req is granted bank 0.
